bg_text_fetcher: RTL and testbench
==================================

# bg_text_fetcher

Text-mode background fetch engine for one GBA PPU background layer. Sits directly upstream of the VRAM read port: on each scanline start it walks the tile map and tile character data through a 14-bit word-addressed, 32-bit VRAM read port and emits 240 palette indices in screen order over a valid/ready stream. It feeds the layer compositor and owns all map/charblock address arithmetic for its layer.

## Interface
- `SCREEN_W`, 240: pixels emitted per line.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `line_start` in 1: one-cycle pulse; begin fetching `line`. Ignored while `busy`.
- `line` in 8: screen Y, 0–159.
- `hofs` / `vofs` in 9: BG scroll offsets.
- `scr_base` in 5: screen base block, ×2 KB.
- `chr_base` in 2: char base block, ×16 KB.
- `scr_size` in 2: 0=256×256, 1=512×256, 2=256×512, 3=512×512.
- `bpp8` in 1: 1 = 8bpp tiles, 0 = 4bpp.
- `vram_addr` out 14: VRAM word address.
- `vram_rdata` in 32: VRAM read data, combinational from `vram_addr`.
- `pix_valid` out 1; `pix_ready` in 1: pixel stream handshake.
- `pix_data` out 8: palette index.
- `pix_transp` out 1: pixel is transparent (colour number 0).
- `busy` out 1: line in progress.
- `line_done` out 1: one-cycle pulse after the 240th pixel is accepted.

## Operation
- States: IDLE, MAP, ROW0, ROW1, EMIT.
  - IDLE→MAP on `line_start`; latch all config inputs.
  - MAP→ROW0; ROW0→ROW1 (8bpp) or →EMIT (4bpp); ROW1→EMIT.
  - EMIT→MAP after pixel 7 of tile accepted, or →IDLE after pixel 239 accepted.
- Coordinates:
  - y = (vofs + line) mod H; x = (hofs + sx) mod W.
  - W/H are 256 or 512 per `scr_size`.
  - tx = x>>3, ty = y>>3.
- Map byte address = scr_base·2048 + sb·2048 + (ty%32)·64 + (tx%32)·2.
  - sb = 0 for size 0; (tx≥32) for 1; (ty≥32) for 2; 2·(ty≥32)+(tx≥32) for 3.
  - Word = byte>>2; halfword select = byte[1].
- Map entry: [9:0] tile, [10] hflip, [11] vflip, [15:12] palette bank.
- Pixel row: r = vflip ? 7−(y%8) : y%8.
  - 4bpp: byte chr_base·16384 + tile·32 + r·4; one word, pixel n = bits [4n+3:4n].
  - 8bpp: byte chr_base·16384 + tile·64 + r·8; two words, pixel n = byte n.
- All VRAM word addresses wrap modulo 2^14.
- Output:
  - 4bpp: `pix_data` = {bank, nibble}.
  - 8bpp: `pix_data` = byte.
  - `pix_transp` = colour number 0.
  - hflip reverses pixel order within the tile.
- First tile: the first hofs[2:0] pixels are skipped internally (not emitted). Fetching stops after exactly 240 emitted pixels; the trailing partial tile is truncated.

## Timing
- Reset: state IDLE; `vram_addr`=0, `pix_valid`=0, `pix_data`=0, `pix_transp`=0, `busy`=0, `line_done`=0.
- `vram_rdata` is registered on the same edge its address is presented; one word per cycle.
- `busy` rises the cycle after `line_start`.
- Per tile, with `pix_ready` held high: 4bpp = 10 cycles, 8bpp = 11 cycles. Skipped pixels cost one cycle each.
- While `pix_valid` && !`pix_ready`: `pix_data`/`pix_transp` are held stable and no state advances.
- `pix_valid` is never retracted before acceptance.
- `line_done` and `busy` fall on the same edge. A `line_start` arriving in that same cycle is ignored.
- `rst_n` asserted mid-line aborts immediately to reset values. No partial `line_done` is produced.

## Configuration
- `BG_FETCH_8BPP_EN` defined: 8bpp mode and ROW1 state are present.
- Undefined: `bpp8` is ignored and treated as 0; ROW1 is not built; 4bpp only.

## Structure
- `gba_ppu_pkg` holds:
  - `bg_map_entry_t` packed struct;
  - fetcher state enum;
  - constants `SCREEN_W`, `SCREEN_H`, `SB_BYTES`=2048, `CB_BYTES`=16384.
- Sub-module `bg_pix_unpack`: combinational; takes row word(s), pixel index, hflip, bank, bpp8 and returns `pix_data`/`pix_transp`.

## Test plan
- Reset: hold `rst_n`=0 → all outputs 0, state IDLE; `line_start` during reset is ignored.
- 4bpp basic:
  - setup: line 0, offsets 0, scr_base 0, chr_base 1; map word 0 low half = 0x3002; word 4112 = 0x87654321;
  - response: first 8 pixels 0x31…0x38, none transparent.
- Hflip + transparency: map entry 0x3402, word 4112 = 0x07654321 → pixels 0x30(transp), 0x37…0x31.
- Fine scroll: hofs=5 → first pixel = tile pixel 5; exactly 240 pixels; `line_done` one cycle after the last accept.
- Backpressure: drop `pix_ready` for 3 cycles at pixel 4 → data held, sequence unchanged, 240 pixels total.
- Wrap: scr_size 1, hofs=500 → first map read from screenblock 1, column 30; after x passes 511, next tile from screenblock 0, column 0.
- With `BG_FETCH_8BPP_EN`: bpp8=1, row words 0x04030201/0x08070605 → pixels 1…8 in 11 cycles/tile.

Source files
------------

// File: rtl/gba_ppu_pkg.sv
// Shared PPU types and constants: BG map entry layout, fetcher states, screen and VRAM block sizes.
package gba_ppu_pkg;

  localparam int SCREEN_W = 240;
  localparam int SCREEN_H = 160;
  localparam int SB_BYTES = 2048;
  localparam int CB_BYTES = 16384;

  typedef struct packed {
    logic [3:0] bank;
    logic       vflip;
    logic       hflip;
    logic [9:0] tile;
  } bg_map_entry_t;

  typedef enum logic [2:0] {
    FS_IDLE = 3'd0,
    FS_MAP  = 3'd1,
    FS_ROW0 = 3'd2,
    FS_ROW1 = 3'd3,
    FS_EMIT = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/bg_text_fetcher_if.sv
// VRAM read port plus pixel stream of one BG fetcher; master = fetcher, slave = VRAM/compositor side.
interface bg_text_fetcher_if;
  logic [13:0] vram_addr;
  logic [31:0] vram_rdata;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_data;
  logic        pix_transp;

  modport master (
    output vram_addr,
    input  vram_rdata,
    output pix_valid,
    input  pix_ready,
    output pix_data,
    output pix_transp
  );

  modport slave (
    input  vram_addr,
    output vram_rdata,
    input  pix_valid,
    output pix_ready,
    input  pix_data,
    input  pix_transp
  );
endinterface

// File: rtl/bg_pix_unpack.sv
// Combinational pixel picker: selects one 4bpp nibble or 8bpp byte from the latched row word(s).
module bg_pix_unpack
  import gba_ppu_pkg::*;
(
  input  logic [31:0] row0,
  input  logic [31:0] row1,
  input  logic [2:0]  pidx,
  input  logic        hflip,
  input  logic [3:0]  bank,
  input  logic        bpp8,
  output logic [7:0]  pix_data,
  output logic        pix_transp
);
  logic [2:0] n;
  logic [3:0] nib;
  logic [7:0] byte_sel;

  assign n = hflip ? ~pidx : pidx;

  always_comb begin
    nib      = row0[{n, 2'b00} +: 4];
    byte_sel = n[2] ? row1[{n[1:0], 3'b000} +: 8] : row0[{n[1:0], 3'b000} +: 8];
    if (bpp8) begin
      pix_data   = byte_sel;
      pix_transp = (byte_sel == 8'h00);
    end else begin
      pix_data   = {bank, nib};
      pix_transp = (nib == 4'h0);
    end
  end
endmodule

// File: rtl/bg_text_fetcher.sv
// Text-mode BG fetcher: walks map and char data per scanline and streams 240 palette indices.
// Define BG_FETCH_8BPP_EN to build 8bpp tiles (ROW1 state); otherwise bpp8 is ignored.
module bg_text_fetcher
  import gba_ppu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       line_start,
  input  logic [7:0] line,
  input  logic [8:0] hofs,
  input  logic [8:0] vofs,
  input  logic [4:0] scr_base,
  input  logic [1:0] chr_base,
  input  logic [1:0] scr_size,
  input  logic       bpp8,
  bg_text_fetcher_if.master bus,
  output logic       busy,
  output logic       line_done
);
  localparam logic [2:0] S_IDLE = 3'(FS_IDLE);
  localparam logic [2:0] S_MAP  = 3'(FS_MAP);
  localparam logic [2:0] S_ROW0 = 3'(FS_ROW0);
`ifdef BG_FETCH_8BPP_EN
  localparam logic [2:0] S_ROW1 = 3'(FS_ROW1);
`endif
  localparam logic [2:0] S_EMIT = 3'(FS_EMIT);

  logic [2:0]    state;
  logic [8:0]    cfg_y, tcol, y_sum, tcol_sum;
  logic [2:0]    cfg_fine, prow, pidx;
  logic [4:0]    cfg_scr_base, sb_blk;
  logic [1:0]    cfg_chr_base, cfg_scr_size, sb;
  logic          cfg_bpp8, bpp8_eff, first_tile;
  logic [7:0]    pcount;
  bg_map_entry_t entry;
  logic [31:0]   row0, row1;
  logic [5:0]    tx, ty;
  logic [13:0]   map_word, chr_word;
  logic          skipping, pix_valid_i, accept, last_pix, step;
  logic [7:0]    up_data;
  logic          up_transp;

`ifdef BG_FETCH_8BPP_EN
  assign bpp8_eff = bpp8;
`else
  assign bpp8_eff = bpp8 & 1'b0;
  assign row1     = '0;
`endif

  // Screen dimensions of 256 drop bit 8, giving the mod-W / mod-H wrap for free.
  assign y_sum    = vofs + {1'b0, line};
  assign tcol_sum = tcol + 9'd8;
  assign tx       = tcol[8:3];
  assign ty       = cfg_y[8:3];

  always_comb begin
    sb = 2'd0;
    case (cfg_scr_size)
      2'd1:    sb = {1'b0, tx[5]};
      2'd2:    sb = {1'b0, ty[5]};
      2'd3:    sb = {ty[5], tx[5]};
      default: sb = 2'd0;
    endcase
  end

  assign sb_blk   = cfg_scr_base + {3'b000, sb};
  assign map_word = 14'(sb_blk * (SB_BYTES / 4)) + {5'b00000, ty[4:0], tx[4:1]};
  assign prow     = entry.vflip ? ~cfg_y[2:0] : cfg_y[2:0];
  assign chr_word = 14'(cfg_chr_base * (CB_BYTES / 4)) +
                    (cfg_bpp8 ? {entry.tile, prow, 1'b0} : {1'b0, entry.tile, prow});

  always_comb begin
    bus.vram_addr = '0;
    case (state)
      S_MAP:  bus.vram_addr = map_word;
      S_ROW0: bus.vram_addr = chr_word;
`ifdef BG_FETCH_8BPP_EN
      S_ROW1: bus.vram_addr = chr_word + 14'd1;
`endif
      default: bus.vram_addr = '0;
    endcase
  end

  // Leading fine-scroll pixels of the first tile burn a cycle each with valid low.
  assign skipping    = (state == S_EMIT) && first_tile && (pidx < cfg_fine);
  assign pix_valid_i = (state == S_EMIT) && !skipping;
  assign accept      = pix_valid_i && bus.pix_ready;
  assign last_pix    = accept && (pcount == 8'(SCREEN_W - 1));
  assign step        = accept || skipping;

  bg_pix_unpack u_unpack (
    .row0       (row0),
    .row1       (row1),
    .pidx       (pidx),
    .hflip      (entry.hflip),
    .bank       (entry.bank),
    .bpp8       (cfg_bpp8),
    .pix_data   (up_data),
    .pix_transp (up_transp)
  );

  assign bus.pix_valid  = pix_valid_i;
  assign bus.pix_data   = pix_valid_i ? up_data : 8'h00;
  assign bus.pix_transp = pix_valid_i & up_transp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cfg_y        <= '0;
      cfg_fine     <= '0;
      cfg_scr_base <= '0;
      cfg_chr_base <= '0;
      cfg_scr_size <= '0;
      cfg_bpp8     <= 1'b0;
      tcol         <= '0;
      entry        <= '0;
      row0         <= '0;
`ifdef BG_FETCH_8BPP_EN
      row1         <= '0;
`endif
      pidx         <= '0;
      first_tile   <= 1'b0;
      pcount       <= '0;
      busy         <= 1'b0;
      line_done    <= 1'b0;
    end else begin
      line_done <= 1'b0;
      case (state)
        S_IDLE: begin
          // The cycle that reports line_done must not restart a line.
          if (line_start && !line_done) begin
            cfg_y        <= {y_sum[8] & scr_size[1], y_sum[7:0]};
            tcol         <= {hofs[8] & scr_size[0], hofs[7:3], 3'b000};
            cfg_fine     <= hofs[2:0];
            cfg_scr_base <= scr_base;
            cfg_chr_base <= chr_base;
            cfg_scr_size <= scr_size;
            cfg_bpp8     <= bpp8_eff;
            pidx         <= '0;
            first_tile   <= 1'b1;
            pcount       <= '0;
            busy         <= 1'b1;
            state        <= S_MAP;
          end
        end
        S_MAP: begin
          entry <= bg_map_entry_t'(tcol[3] ? bus.vram_rdata[31:16] : bus.vram_rdata[15:0]);
          state <= S_ROW0;
        end
        S_ROW0: begin
          row0 <= bus.vram_rdata;
`ifdef BG_FETCH_8BPP_EN
          state <= cfg_bpp8 ? S_ROW1 : S_EMIT;
`else
          state <= S_EMIT;
`endif
        end
`ifdef BG_FETCH_8BPP_EN
        S_ROW1: begin
          row1  <= bus.vram_rdata;
          state <= S_EMIT;
        end
`endif
        S_EMIT: begin
          if (step) pidx <= pidx + 3'd1;
          if (accept) pcount <= pcount + 8'd1;
          if (last_pix) begin
            busy      <= 1'b0;
            line_done <= 1'b1;
            state     <= S_IDLE;
          end else if (step && pidx == 3'd7) begin
            first_tile <= 1'b0;
            tcol       <= {tcol_sum[8] & cfg_scr_size[0], tcol_sum[7:0]};
            state      <= S_MAP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bg_text_fetcher.sv
// Directed self-checking bench for bg_text_fetcher using a flat 16K-word VRAM model.
module tb_bg_text_fetcher;
  import gba_ppu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line_start = 1'b0;
  logic [7:0] line = '0;
  logic [8:0] hofs = '0, vofs = '0;
  logic [4:0] scr_base = '0;
  logic [1:0] chr_base = '0, scr_size = '0;
  logic       bpp8 = 1'b0;
  logic       busy, line_done;

  bg_text_fetcher_if vif();

  logic [31:0] vram [0:16383];
  assign vif.vram_rdata = vram[vif.vram_addr];

  bg_text_fetcher dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_start (line_start),
    .line       (line),
    .hofs       (hofs),
    .vofs       (vofs),
    .scr_base   (scr_base),
    .chr_base   (chr_base),
    .scr_size   (scr_size),
    .bpp8       (bpp8),
    .bus        (vif),
    .busy       (busy),
    .line_done  (line_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [7:0] capData[$];
  logic       capTransp[$];
  int         mapAddrs[$];
  int         firstValidCyc, lastAcceptCyc;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clearVram();
    for (int i = 0; i < 16384; i++) vram[i] = 32'h0;
  endtask

  task automatic fillMapRow(input int base, input logic [31:0] w);
    for (int i = 0; i < 16; i++) vram[base + i] = w;
  endtask

  // Run one line; optionally drop ready for 3 cycles when pixel stallAt is offered.
  task automatic applyStimulus(input logic [7:0] ln, input logic [8:0] ho, input logic [8:0] vo,
                               input logic [4:0] sbase, input logic [1:0] cbase,
                               input logic [1:0] ssize, input logic b8,
                               input int stallAt, input logic [7:0] stallExp);
    int  cyc;
    int  stallLeft;
    bit  stalled;
    bit  done;
    capData.delete();
    capTransp.delete();
    mapAddrs.delete();
    firstValidCyc = -1;
    lastAcceptCyc = -1;
    stallLeft = 0;
    stalled = 0;
    done = 0;
    @(negedge clk);
    line = ln; hofs = ho; vofs = vo; scr_base = sbase; chr_base = cbase;
    scr_size = ssize; bpp8 = b8; line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    checkOutput("busy_rise", busy, 1'b1);
    cyc = 0;
    while (!done && cyc < 2000) begin
      if (busy && vif.vram_addr != 14'd0 && vif.vram_addr < 14'd4096)
        mapAddrs.push_back(int'(vif.vram_addr));
      if (stallLeft > 0) begin
        vif.pix_ready = 1'b0;
        stallLeft--;
        checkOutput("stall_hold", vif.pix_data, stallExp);
      end else if (vif.pix_valid && !stalled && capData.size() == stallAt) begin
        stalled = 1;
        stallLeft = 2;
        vif.pix_ready = 1'b0;
        checkOutput("stall_hold", vif.pix_data, stallExp);
      end else begin
        vif.pix_ready = 1'b1;
      end
      if (vif.pix_valid && vif.pix_ready) begin
        capData.push_back(vif.pix_data);
        capTransp.push_back(vif.pix_transp);
        if (capData.size() == 1) firstValidCyc = cyc;
        if (capData.size() == SCREEN_W) begin
          lastAcceptCyc = cyc;
          done = 1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    vif.pix_ready = 1'b1;
    checkOutput("pix_count", capData.size(), SCREEN_W);
    checkOutput("line_done_pulse", line_done, 1'b1);
    checkOutput("busy_fall", busy, 1'b0);
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    checkOutput("line_done_clear", line_done, 1'b0);
    checkOutput("restart_ignored", busy, 1'b0);
  endtask

  initial begin
    logic [7:0] expRow [8];
    vif.pix_ready = 1'b1;
    clearVram();

    // Reset: outputs idle, line_start held during reset has no effect.
    line_start = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_vram_addr", vif.vram_addr, 14'd0);
    checkOutput("rst_pix_valid", vif.pix_valid, 1'b0);
    checkOutput("rst_pix_data", vif.pix_data, 8'h00);
    checkOutput("rst_pix_transp", vif.pix_transp, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_line_done", line_done, 1'b0);
    line_start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_start_ignored", busy, 1'b0);

    // 4bpp basic: tile 2, bank 3 everywhere on map row 0.
    fillMapRow(0, 32'h3002_3002);
    vram[4112] = 32'h8765_4321;
    applyStimulus(8'd0, 9'd0, 9'd0, 5'd0, 2'd1, 2'd0, 1'b0, -1, 8'h00);
    for (int k = 0; k < 8; k++) begin
      checkOutput("basic_data", capData[k], 8'h31 + 8'(k));
      checkOutput("basic_transp", capTransp[k], 1'b0);
    end
    checkOutput("basic_last", capData[SCREEN_W - 1], 8'h38);
    checkOutput("basic_first_lat", firstValidCyc, 2);
    checkOutput("basic_line_cycles", lastAcceptCyc - firstValidCyc, 297);

    // Reset mid-line aborts at once.
    @(negedge clk);
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_valid", vif.pix_valid, 1'b0);
    checkOutput("abort_line_done", line_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("abort_no_done", line_done, 1'b0);

    // Hflip with a transparent colour 0.
    fillMapRow(0, 32'h3402_3402);
    vram[4112] = 32'h0765_4321;
    expRow = '{8'h30, 8'h37, 8'h36, 8'h35, 8'h34, 8'h33, 8'h32, 8'h31};
    applyStimulus(8'd0, 9'd0, 9'd0, 5'd0, 2'd1, 2'd0, 1'b0, -1, 8'h00);
    for (int k = 0; k < 8; k++) begin
      checkOutput("hflip_data", capData[k], expRow[k]);
      checkOutput("hflip_transp", capTransp[k], (k == 0) ? 1'b1 : 1'b0);
    end

    // Fine scroll of 5: line starts at tile pixel 5.
    fillMapRow(0, 32'h3002_3002);
    vram[4112] = 32'h8765_4321;
    applyStimulus(8'd0, 9'd5, 9'd0, 5'd0, 2'd1, 2'd0, 1'b0, -1, 8'h00);
    for (int k = 0; k < SCREEN_W; k++)
      checkOutput("fine_data", capData[k], 8'h31 + 8'((k + 5) % 8));

    // Backpressure at pixel 4 for three cycles.
    applyStimulus(8'd0, 9'd0, 9'd0, 5'd0, 2'd1, 2'd0, 1'b0, 4, 8'h35);
    for (int k = 0; k < SCREEN_W; k++)
      checkOutput("bp_data", capData[k], 8'h31 + 8'(k % 8));

    // Vflip on line 3 selects row 4.
    clearVram();
    fillMapRow(0, 32'h3802_3802);
    vram[4116] = 32'h1111_1111;
    applyStimulus(8'd3, 9'd0, 9'd0, 5'd0, 2'd1, 2'd0, 1'b0, -1, 8'h00);
    checkOutput("vflip_data", capData[0], 8'h31);
    checkOutput("vflip_transp", capTransp[0], 1'b0);

    // Horizontal wrap in a 512-wide map based at screenblock 1.
    clearVram();
    vram[1039] = 32'h3002_3002;
    vram[512]  = 32'h3002_3002;
    vram[4112] = 32'h8765_4321;
    applyStimulus(8'd0, 9'd500, 9'd0, 5'd1, 2'd1, 2'd1, 1'b0, -1, 8'h00);
    checkOutput("wrap_map0", mapAddrs[0], 1039);
    checkOutput("wrap_map1", mapAddrs[1], 1039);
    checkOutput("wrap_map2", mapAddrs[2], 512);
    checkOutput("wrap_first", capData[0], 8'h35);
    checkOutput("wrap_col31", capData[4], 8'h31);
    checkOutput("wrap_col0", capData[12], 8'h31);
    checkOutput("wrap_empty", capData[28], 8'h00);
    checkOutput("wrap_empty_tr", capTransp[28], 1'b1);

`ifdef BG_FETCH_8BPP_EN
    // 8bpp: two row words per tile, 11 cycles per tile.
    clearVram();
    fillMapRow(0, 32'h0002_0002);
    vram[4128] = 32'h0403_0201;
    vram[4129] = 32'h0807_0605;
    applyStimulus(8'd0, 9'd0, 9'd0, 5'd0, 2'd1, 2'd0, 1'b1, -1, 8'h00);
    for (int k = 0; k < 8; k++)
      checkOutput("bpp8_data", capData[k], 8'(k + 1));
    checkOutput("bpp8_first_lat", firstValidCyc, 3);
    checkOutput("bpp8_line_cycles", lastAcceptCyc - firstValidCyc, 326);
`endif

    $display("[TB] lines run on a %0dx%0d screen", SCREEN_W, SCREEN_H);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
